color_manager_config_arbiter: RTL and testbench

- Shares the single configuration bus (C_Addr/C_Data/C_Valid/C_Rdy) among NUM_REQ requesters, e.g. the UART config manager and a power-on default-config sequencer.
- Uses round-robin arbitration. Each granted write is latched, then issued as a one-cycle C_Valid pulse once the target asserts C_Rdy.
- Sits between the config-producing blocks and the UART/VGA config targets.

---
 rtl/color_manager_config_arbiter.sv | 134 +++++++++++++
 tb/tb_color_manager_config_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/color_manager_config_arbiter.sv
// color_manager_config_arbiter: round-robin owner of the shared config write bus; define COLOR_MANAGER_CONFIG_ARB_TIMEOUT_EN to drop writes whose target never becomes ready
module color_manager_config_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int C_ADDR_WIDTH   = 3,
    parameter int C_DATA_WIDTH   = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             Clk,
    input  logic                             Rst,
    input  logic [NUM_REQ-1:0]               Req_Valid,
    input  logic [NUM_REQ*C_ADDR_WIDTH-1:0]  Req_Addr,
    input  logic [NUM_REQ*C_DATA_WIDTH-1:0]  Req_Data,
    output logic [NUM_REQ-1:0]               Req_Rdy,
    input  logic                             C_Rdy,
    output logic [C_ADDR_WIDTH-1:0]          C_Addr,
    output logic [C_DATA_WIDTH-1:0]          C_Data,
    output logic                             C_Valid,
    output logic [NUM_REQ-1:0]               Grant,
    output logic                             Busy,
    output logic                             Timeout
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    state_t                    state_q;
    logic [IW-1:0]             last_q;
    logic [IW-1:0]             sel_d;
    logic [IW-1:0]             idx_d;
    logic                      found_d;
    logic [NUM_REQ-1:0]        onehot_d;
    logic [NUM_REQ-1:0]        req_rdy_q;
    logic [NUM_REQ-1:0]        grant_q;
    logic [C_ADDR_WIDTH-1:0]   c_addr_q;
    logic [C_DATA_WIDTH-1:0]   c_data_q;
    logic                      c_valid_q;
    logic                      busy_q;

`ifdef COLOR_MANAGER_CONFIG_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]             cnt_q;
    logic                      timeout_q;
    assign Timeout = timeout_q;
`else
    assign Timeout = 1'b0;
`endif

    assign Req_Rdy = req_rdy_q;
    assign Grant   = grant_q;
    assign C_Addr  = c_addr_q;
    assign C_Data  = c_data_q;
    assign C_Valid = c_valid_q;
    assign Busy    = busy_q;

    // Pick the first requesting index after the last winner; scanning downward lets the nearest one overwrite
    always_comb begin
        sel_d   = '0;
        idx_d   = '0;
        found_d = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx_d = IW'((int'(last_q) + k) % NUM_REQ);
            if (Req_Valid[idx_d]) begin
                sel_d   = idx_d;
                found_d = 1'b1;
            end
        end
        onehot_d = NUM_REQ'(1) << sel_d;
    end

    // Arbitration FSM: latch the winner, wait for the target, strobe once, then hold a dead cycle
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= IDLE;
            last_q    <= IW'(NUM_REQ - 1);
            req_rdy_q <= '0;
            grant_q   <= '0;
            c_addr_q  <= '0;
            c_data_q  <= '0;
            c_valid_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef COLOR_MANAGER_CONFIG_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            req_rdy_q <= '0;
            c_valid_q <= 1'b0;
`ifdef COLOR_MANAGER_CONFIG_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        c_addr_q  <= Req_Addr[int'(sel_d)*C_ADDR_WIDTH +: C_ADDR_WIDTH];
                        c_data_q  <= Req_Data[int'(sel_d)*C_DATA_WIDTH +: C_DATA_WIDTH];
                        grant_q   <= onehot_d;
                        req_rdy_q <= onehot_d;
                        last_q    <= sel_d;
                        busy_q    <= 1'b1;
                        state_q   <= ISSUE;
`ifdef COLOR_MANAGER_CONFIG_ARB_TIMEOUT_EN
                        cnt_q     <= '0;
`endif
                    end
                end
                ISSUE: begin
                    if (C_Rdy) begin
                        c_valid_q <= 1'b1;
                        state_q   <= GAP;
                    end
`ifdef COLOR_MANAGER_CONFIG_ARB_TIMEOUT_EN
                    else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_q <= 1'b1;
                        grant_q   <= '0;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
`endif
                end
                GAP: begin
                    // First GAP cycle carries the strobe; the second is the dead cycle before release
                    if (!c_valid_q) begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_color_manager_config_arbiter.sv
// tb_color_manager_config_arbiter: directed checks of grant order, strobe timing, reset abort and timeout
module tb_color_manager_config_arbiter;
    localparam int N  = 2;
    localparam int AW = 3;
    localparam int DW = 12;
    localparam int TO = 8;
`ifdef COLOR_MANAGER_CONFIG_ARB_TIMEOUT_EN
    localparam int STALL = 5;
`else
    localparam int STALL = 10;
`endif

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic [N-1:0]  Req_Valid = '0;
    logic [N*AW-1:0] Req_Addr = '0;
    logic [N*DW-1:0] Req_Data = '0;
    logic [N-1:0]  Req_Rdy;
    logic          C_Rdy = 1'b0;
    logic [AW-1:0] C_Addr;
    logic [DW-1:0] C_Data;
    logic          C_Valid;
    logic [N-1:0]  Grant;
    logic          Busy;
    logic          Timeout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    color_manager_config_arbiter #(
        .NUM_REQ(N), .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Req_Valid(Req_Valid), .Req_Addr(Req_Addr), .Req_Data(Req_Data),
        .Req_Rdy(Req_Rdy), .C_Rdy(C_Rdy), .C_Addr(C_Addr), .C_Data(C_Data), .C_Valid(C_Valid),
        .Grant(Grant), .Busy(Busy), .Timeout(Timeout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge Clk);
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        step(2);
        Rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Req_Addr = {3'h5, 3'h2};
        Req_Data = {12'h555, 12'h0A5};
        step(2);
        chk("rst_req_rdy", 32'(Req_Rdy), 0);
        chk("rst_grant", 32'(Grant), 0);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_c_valid", 32'(C_Valid), 0);
        chk("rst_c_addr", 32'(C_Addr), 0);
        chk("rst_c_data", 32'(C_Data), 0);
        chk("rst_timeout", 32'(Timeout), 0);
        Rst = 1'b0;
        step();

        // single write latency
        Req_Valid = 2'b01;
        C_Rdy = 1'b1;
        step();
        chk("t1_req_rdy_c1", 32'(Req_Rdy), 1);
        chk("t1_grant_c1", 32'(Grant), 1);
        chk("t1_busy_c1", 32'(Busy), 1);
        chk("t1_c_valid_c1", 32'(C_Valid), 0);
        Req_Valid = 2'b00;
        step();
        chk("t1_c_valid_c2", 32'(C_Valid), 1);
        chk("t1_c_addr_c2", 32'(C_Addr), 2);
        chk("t1_c_data_c2", 32'(C_Data), 32'h0A5);
        chk("t1_req_rdy_c2", 32'(Req_Rdy), 0);
        step();
        chk("t1_c_valid_c3", 32'(C_Valid), 0);
        chk("t1_busy_c3", 32'(Busy), 1);
        step();
        chk("t1_busy_c4", 32'(Busy), 0);
        chk("t1_grant_c4", 32'(Grant), 0);
        chk("t1_c_addr_held", 32'(C_Addr), 2);

        // alternating grants with both requesting
        do_reset();
        Req_Addr = {3'h5, 3'h1};
        Req_Data = {12'h555, 12'h111};
        Req_Valid = 2'b11;
        C_Rdy = 1'b1;
        for (int j = 0; j < 4; j++) begin
            step();
            chk($sformatf("t2_grant_%0d", j), 32'(Grant), (j % 2) ? 2 : 1);
            chk($sformatf("t2_req_rdy_%0d", j), 32'(Req_Rdy), (j % 2) ? 2 : 1);
            step();
            chk($sformatf("t2_c_valid_%0d", j), 32'(C_Valid), 1);
            chk($sformatf("t2_c_addr_%0d", j), 32'(C_Addr), (j % 2) ? 5 : 1);
            chk($sformatf("t2_c_data_%0d", j), 32'(C_Data), (j % 2) ? 32'h555 : 32'h111);
            step();
            chk($sformatf("t2_c_valid_off_%0d", j), 32'(C_Valid), 0);
            step();
            chk($sformatf("t2_busy_%0d", j), 32'(Busy), 0);
        end
        Req_Valid = 2'b00;
        step();
        chk("t2_idle_grant", 32'(Grant), 0);

        // target stalls, then accepts
        Req_Valid = 2'b01;
        C_Rdy = 1'b0;
        step();
        chk("t3_grant", 32'(Grant), 1);
        Req_Valid = 2'b00;
        for (int j = 0; j < STALL; j++) begin
            step();
            chk($sformatf("t3_stall_c_valid_%0d", j), 32'(C_Valid), 0);
            chk($sformatf("t3_stall_grant_%0d", j), 32'(Grant), 1);
        end
        C_Rdy = 1'b1;
        step();
        chk("t3_c_valid", 32'(C_Valid), 1);
        chk("t3_c_addr", 32'(C_Addr), 1);
        step();
        chk("t3_c_valid_once", 32'(C_Valid), 0);
        step();
        chk("t3_busy_idle", 32'(Busy), 0);
        chk("t3_timeout", 32'(Timeout), 0);

`ifdef COLOR_MANAGER_CONFIG_ARB_TIMEOUT_EN
        // timeout drops the write, then the waiting requester is served
        Req_Valid = 2'b01;
        C_Rdy = 1'b0;
        step();
        chk("t4_grant0", 32'(Grant), 1);
        Req_Valid = 2'b10;
        for (int j = 2; j <= TO; j++) begin
            step();
            chk($sformatf("t4_no_timeout_c%0d", j), 32'(Timeout), 0);
            chk($sformatf("t4_no_valid_c%0d", j), 32'(C_Valid), 0);
        end
        step();
        chk("t4_timeout", 32'(Timeout), 1);
        chk("t4_busy", 32'(Busy), 0);
        chk("t4_grant_clr", 32'(Grant), 0);
        chk("t4_c_valid", 32'(C_Valid), 0);
        step();
        chk("t4_timeout_pulse", 32'(Timeout), 0);
        chk("t4_grant1", 32'(Grant), 2);
        Req_Valid = 2'b00;
        C_Rdy = 1'b1;
        step();
        chk("t4_c_valid1", 32'(C_Valid), 1);
        chk("t4_c_addr1", 32'(C_Addr), 5);
        step(2);
        chk("t4_busy_end", 32'(Busy), 0);
`endif

        // reset in ISSUE abandons the write
        Req_Valid = 2'b01;
        C_Rdy = 1'b0;
        step();
        chk("t5_grant", 32'(Grant), 1);
        Req_Valid = 2'b00;
        Rst = 1'b1;
        C_Rdy = 1'b1;
        step();
        chk("t5_rst_grant", 32'(Grant), 0);
        chk("t5_rst_busy", 32'(Busy), 0);
        chk("t5_rst_c_valid", 32'(C_Valid), 0);
        chk("t5_rst_c_addr", 32'(C_Addr), 0);
        Rst = 1'b0;
        step();
        chk("t5_no_valid", 32'(C_Valid), 0);
        chk("t5_idle_busy", 32'(Busy), 0);
        Req_Valid = 2'b11;
        step();
        chk("t5_first_grant", 32'(Grant), 1);
        Req_Valid = 2'b00;
        step(3);
        chk("t5_busy_end", 32'(Busy), 0);

        // withdrawn request is never granted
        Req_Valid = 2'b01;
        C_Rdy = 1'b0;
        step();
        chk("t6_grant0", 32'(Grant), 1);
        Req_Valid = 2'b10;
        step();
        Req_Valid = 2'b00;
        chk("t6_req_rdy", 32'(Req_Rdy), 0);
        C_Rdy = 1'b1;
        for (int j = 0; j < 6; j++) begin
            step();
            chk($sformatf("t6_no_rdy1_%0d", j), 32'(Req_Rdy[1]), 0);
            chk($sformatf("t6_no_grant1_%0d", j), 32'(Grant[1]), 0);
        end
        chk("t6_idle", 32'(Busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
